// File: rtl/mmt_result_packer.sv
// mmt_result_packer: buffers single-cycle MMT result pulses in a word FIFO and
// serializes each word LSB-first as NBYTES bytes on a valid/ready byte stream.
module mmt_result_packer #(
    parameter int DATA_W = 50,
    parameter int DEPTH  = 4,
    parameter int NBYTES = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_value,
    output logic                     out_valid,
    output logic [7:0]               out_byte,
    output logic                     out_last,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(NBYTES);
    localparam int SW = NBYTES * 8;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_shreg;
    logic [IW-1:0]     r_idx;
    logic              r_ovf;
    logic              w_last;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;

    assign w_last   = r_idx == IW'(NBYTES - 1);
    assign w_accept = (r_state == S_SEND) && out_ready;

    // A pop is the serializer loading the head, either from IDLE or right after a word's last byte.
    always_comb begin
        w_state_n = r_state;
        w_pop     = 1'b0;
        if (r_state == S_IDLE) begin
            w_pop     = r_cnt != '0;
            w_state_n = (r_cnt != '0) ? S_SEND : S_IDLE;
        end else if (w_accept && w_last) begin
            w_pop     = r_cnt != '0;
            w_state_n = (r_cnt != '0) ? S_SEND : S_IDLE;
        end
    end

    // A full FIFO still takes a word when the head slot is freed on the same edge.
    assign w_push = in_valid && ((r_cnt != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= in_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_pop) begin
                r_shreg <= SW'(r_mem[r_rp]);
                r_idx   <= '0;
            end else if (w_accept) begin
                r_shreg <= r_shreg >> 8;
                r_idx   <= r_idx + 1'b1;
            end
            r_ovf <= (in_valid && !w_push) || (r_ovf && !clr_ovf);
        end
    end

    assign out_valid = r_state == S_SEND;
    assign out_byte  = r_shreg[7:0];
    assign out_last  = out_valid && w_last;
    assign overflow  = r_ovf;
    assign fifo_cnt  = r_cnt;
endmodule

// File: doc/mmt_result_packer.md
Name: mmt_result_packer

Overview:
- Downstream stage of the MMT matrix-multiplication core.
- Captures each single-cycle 50-bit result pulse (out_valid/out_value of MMT) into a small word FIFO.
- Serializes each captured word into 7 bytes, LSB first, zero-padded to 56 bits, on a valid/ready byte interface toward the host/readout side.
- Purpose: the MMT result pulse can never be lost to downstream backpressure unless the FIFO is genuinely full. A full-FIFO drop is flagged.

Parameters:
- DATA_W, 50: result word width; must match MMT out_value.
- DEPTH, 4: word FIFO depth; power of two, ≥2.
- NBYTES, 7: bytes per word, ceil(DATA_W/8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state.
- in_valid  in  1  result strobe; connect to MMT out_valid; one-cycle pulses, any spacing including back-to-back.
- in_value  in  DATA_W  result word; connect to MMT out_value; sampled only when in_valid=1.
- out_valid  out  1  out_byte is valid.
- out_byte  out  8  current byte.
- out_last  out  1  high with byte index NBYTES-1 of a word.
- out_ready  in  1  downstream accepts the byte when out_valid&&out_ready at a rising edge.
- clr_ovf  in  1  synchronous clear of overflow.
- overflow  out  1  sticky: a result was dropped.
- fifo_cnt  out  $clog2(DEPTH)+1  number of words in the FIFO, excluding the word loaded in the serializer.

Behaviour:
- Reset values: out_valid=0, out_byte=0, out_last=0, overflow=0, fifo_cnt=0. Serializer state=IDLE; FIFO pointers=0. Reset mid-word discards the word in flight and all queued words. No byte is emitted until a new in_valid arrives.
- Push: at an edge with in_valid=1, write in_value into the FIFO if fifo_cnt<DEPTH, or if fifo_cnt==DEPTH and a pop occurs in the same edge. Otherwise drop the word and set overflow=1.
- overflow: clr_ovf=1 clears it at the edge. If a drop and clr_ovf occur at the same edge, overflow=1 (set wins).
- Pop: occurs whenever the serializer loads the FIFO head. That slot is freed at the same edge.
- Serializer register: 56-bit shift register shreg, 3-bit byte index idx. Outputs are registered: out_byte=shreg[7:0], out_last=(idx==NBYTES-1).
- State IDLE (out_valid=0): if fifo_cnt>0, load shreg={6'b0,head}, idx=0, pop, go to SEND.
- State SEND (out_valid=1): hold out_byte/out_last stable while out_ready=0. On accept with idx<NBYTES-1: shreg>>=8, idx+=1.
- On accept with idx==NBYTES-1: if fifo_cnt>0, load next head, idx=0, pop, stay in SEND; back-to-back words have no bubble. Otherwise go to IDLE; out_valid=0 next cycle.
- Latency: in_valid sampled at edge t with an empty FIFO and serializer IDLE gives the first byte with out_valid=1 after edge t+1 (visible in the second cycle after the pulse).
- Simultaneous push and pop in one edge: fifo_cnt is unchanged.
- fifo_cnt counts 0..DEPTH. Pointers wrap modulo DEPTH.
- Throughput: one byte per cycle with out_ready held at 1. The sustained word rate is 1 per NBYTES cycles. Faster bursts are absorbed by the FIFO, whose effective capacity is DEPTH+1 words including the serializer.
- No combinational path from in_valid/in_value or out_ready to any output.

Test Plan:
- Single word: after reset, pulse in_valid with in_value=50'h3_0123_4567_89AB, out_ready=1.
  -> out_valid rises 2 cycles later; bytes AB,89,67,45,23,01,03 on 7 consecutive cycles; out_last only on 03; then out_valid=0.
- Backpressure: same word with out_ready toggling 1,0,0,1,...
  -> each byte is held stable while out_ready=0; the byte sequence is unchanged; no duplicates or skips.
- Back-to-back: 3 pulses on consecutive cycles with values 1, 2, 3, out_ready=1.
  -> 21 bytes with no gaps; out_last at bytes 7, 14 and 21; fifo_cnt peaks at 2.
- Overflow: out_ready=0, 6 consecutive pulses with values 10..15.
  -> words 10..14 retained (1 in serializer + 4 in FIFO, fifo_cnt=4); 15 dropped; overflow=1.
  -> out_ready=1 then yields words 10..14 in order.
  -> clr_ovf pulse gives overflow=0.
- Full plus simultaneous pop: with FIFO full, assert in_valid on the same edge that the last byte of the serializer word is accepted.
  -> word accepted; overflow stays 0; fifo_cnt stays 4.
- Reset mid-word: assert rst after 3 bytes of a word are accepted.
  -> all outputs 0 immediately; fifo_cnt=0; after deassertion no bytes until a new pulse; a new word is serialized correctly from byte 0.
